latch_bank_arbiter: RTL

Round-robin write controller that shares one bank of DEPTH level-sensitive D latches, each WIDTH bits wide, between NREQ requesters. It arbitrates the requests and captures the winner's address and data. It then drives the bank through a glitch-safe setup → gate → hold sequence, so latch data is always stable while any gate is open. It sits between the requester blocks and the latch bank, and it is the only driver of the bank's D and gate inputs.

---
 rtl/latch_bank_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter
//   Round-robin write controller for a shared bank of DEPTH level-sensitive
//   latches. A request won in IDLE has its address and data captured, then
//   the bank is driven through SETUP -> GATE (GATE_CYC cycles) -> HOLD so the
//   latch D bus is stable whenever a gate is open.
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      synchronous active-low reset
//   req_i        per-requester write request (level)
//   req_addr_i   requester i address at [i*AW +: AW]
//   req_data_i   requester i data at [i*WIDTH +: WIDTH]
//   gnt_o        one-hot grant, SETUP through HOLD
//   ack_o        one-cycle completion pulse (HOLD)
//   err_o        with ack when captured address >= DEPTH
//   lat_d_o      latch D bus, changes only on IDLE->SETUP
//   lat_en_o     one-hot latch gate, nonzero only in GATE
//   busy_o       high outside IDLE
module latch_bank_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int GATE_CYC = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*AW-1:0]    req_addr_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       ack_o,
  output logic                  err_o,
  output logic [WIDTH-1:0]      lat_d_o,
  output logic [DEPTH-1:0]      lat_en_o,
  output logic                  busy_o
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_GATE, S_HOLD} state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          win_q, win_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NREQ-1:0]        gnt_q, gnt_d, ack_q, ack_d;
  logic                   err_q, err_d, busy_q, busy_d;
  logic [WIDTH-1:0]       lat_d_q, lat_d_d;
  logic [DEPTH-1:0]       lat_en_q, lat_en_d;

  logic [NREQ-1:0][AW-1:0]    addr_arr;
  logic [NREQ-1:0][WIDTH-1:0] data_arr;
  assign addr_arr = req_addr_i;
  assign data_arr = req_data_i;

  // Round-robin search starting at rr_ptr; idx is one bit wider so the
  // rr_ptr+k sum can be folded back below NREQ for non-power-of-2 NREQ.
  logic          found;
  logic [PW-1:0] pick;
  always_comb begin
    logic [PW:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req_i[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  // Gate decode of the captured address; out-of-range opens nothing.
  logic             in_rng;
  logic [DEPTH-1:0] dec;
  assign in_rng = 32'(addr_q) < 32'(DEPTH);
  assign dec    = in_rng ? (DEPTH'(1) << addr_q) : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    err_d    = 1'b0;
    busy_d   = busy_q;
    lat_d_d  = lat_d_q;
    lat_en_d = '0;
    unique case (state_q)
      S_IDLE: if (found) begin
        state_d = S_SETUP;
        win_d   = pick;
        addr_d  = addr_arr[pick];
        lat_d_d = data_arr[pick];
        gnt_d   = NREQ'(1) << pick;
        busy_d  = 1'b1;
      end
      S_SETUP: begin
        state_d  = S_GATE;
        cnt_d    = CW'(GATE_CYC - 1);
        lat_en_d = dec;
      end
      S_GATE: begin
        if (cnt_q == '0) begin
          // gate closes on the same edge that raises ack
          state_d = S_HOLD;
          ack_d   = gnt_q;
          err_d   = !in_rng;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          lat_en_d = dec;
        end
      end
      S_HOLD: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        busy_d   = 1'b0;
        rr_ptr_d = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign busy_o   = busy_q;
  assign lat_d_o  = lat_d_q;
  assign lat_en_o = lat_en_q;

endmodule
